csr_trap_ctrl: RTL and testbench

- Machine-mode trap sequencer. Sits beside the execute stage and drives the CSR register file's write port.
- On ECALL, EBREAK or an enabled timer interrupt, it stalls the pipeline and writes mepc, mcause and mstatus, one CSR per cycle. It then redirects fetch to the mtvec target.
- On MRET, it restores mstatus and redirects fetch to mepc.

---
 rtl/csr_trap_ctrl.sv | 157 +++++++++++++++
 tb/tb_csr_trap_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/csr_trap_ctrl.sv
// Machine-mode trap sequencer: on ECALL/EBREAK/timer interrupt it writes mepc, mcause and
// mstatus one per cycle and then redirects fetch; on MRET it restores mstatus and returns to mepc.
module csr_trap_ctrl #(
  parameter logic [31:0] MCAUSE_ECALL  = 32'd11,
  parameter logic [31:0] MCAUSE_EBREAK = 32'd3,
  parameter logic [31:0] MCAUSE_MTIMER = 32'h8000_0007
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inst_ecall_i,
  input  logic        inst_ebreak_i,
  input  logic        inst_mret_i,
  input  logic [31:0] inst_addr_i,
  input  logic        ex_busy_i,
  input  logic        timer_irq_i,
  input  logic [31:0] mstatus_i,
  input  logic [31:0] mie_i,
  input  logic [31:0] mtvec_i,
  input  logic [31:0] mepc_i,
  output logic        csr_we_o,
  output logic [11:0] csr_waddr_o,
  output logic [31:0] csr_wdata_o,
  output logic        hold_o,
  output logic        jump_flag_o,
  output logic [31:0] jump_addr_o
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] W_MEPC    = 3'd1;
  localparam logic [2:0] W_MCAUSE  = 3'd2;
  localparam logic [2:0] W_MSTATUS = 3'd3;
  localparam logic [2:0] T_JUMP    = 3'd4;
  localparam logic [2:0] R_MSTATUS = 3'd5;
  localparam logic [2:0] R_JUMP    = 3'd6;

  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE  = 12'h342;

  logic [2:0]  state_q, state_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] cause_q, cause_d;
  logic        csr_we_d;
  logic [11:0] csr_waddr_d;
  logic [31:0] csr_wdata_d;
  logic        jump_flag_d;
  logic [31:0] jump_addr_d;
  logic        accept;
  logic        irq_ok;
  logic [31:0] trap_mstatus;
  logic [31:0] mret_mstatus;
  logic [31:0] mtvec_base;
  logic [31:0] trap_target;
  logic        unused_bits;

  assign irq_ok = timer_irq_i & mstatus_i[3] & mie_i[7] & ~ex_busy_i;

  always_comb begin
    trap_mstatus         = mstatus_i;
    trap_mstatus[7]      = mstatus_i[3];
    trap_mstatus[3]      = 1'b0;
    trap_mstatus[12:11]  = 2'b11;
    mret_mstatus         = mstatus_i;
    mret_mstatus[3]      = mstatus_i[7];
    mret_mstatus[7]      = 1'b1;
    mret_mstatus[12:11]  = 2'b11;
  end

  // Vectored mode only for interrupts; 2'b10/2'b11 fall back to direct.
  assign mtvec_base  = {mtvec_i[31:2], 2'b00};
  assign trap_target = (mtvec_i[1:0] == 2'b01 && cause_q[31]) ?
                       mtvec_base + {cause_q[29:0], 2'b00} : mtvec_base;

  assign unused_bits = ^{mie_i[31:8], mie_i[6:0], cause_q[30]};

  always_comb begin
    state_d     = state_q;
    epc_d       = epc_q;
    cause_d     = cause_q;
    csr_we_d    = 1'b0;
    csr_waddr_d = 12'h000;
    csr_wdata_d = 32'h0;
    jump_flag_d = 1'b0;
    jump_addr_d = 32'h0;
    accept      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (inst_ecall_i || inst_ebreak_i || (!inst_mret_i && irq_ok)) begin
          accept  = 1'b1;
          epc_d   = inst_addr_i;
          cause_d = inst_ecall_i  ? MCAUSE_ECALL  :
                    inst_ebreak_i ? MCAUSE_EBREAK : MCAUSE_MTIMER;
          state_d     = W_MEPC;
          csr_we_d    = 1'b1;
          csr_waddr_d = ADDR_MEPC;
          csr_wdata_d = epc_d;
        end else if (inst_mret_i) begin
          accept      = 1'b1;
          state_d     = R_MSTATUS;
          csr_we_d    = 1'b1;
          csr_waddr_d = ADDR_MSTATUS;
          csr_wdata_d = mret_mstatus;
        end
      end
      W_MEPC: begin
        state_d     = W_MCAUSE;
        csr_we_d    = 1'b1;
        csr_waddr_d = ADDR_MCAUSE;
        csr_wdata_d = cause_q;
      end
      W_MCAUSE: begin
        state_d     = W_MSTATUS;
        csr_we_d    = 1'b1;
        csr_waddr_d = ADDR_MSTATUS;
        csr_wdata_d = trap_mstatus;
      end
      W_MSTATUS: begin
        state_d     = T_JUMP;
        jump_flag_d = 1'b1;
        jump_addr_d = trap_target;
      end
      R_MSTATUS: begin
        state_d     = R_JUMP;
        jump_flag_d = 1'b1;
        jump_addr_d = mepc_i;
      end
      T_JUMP, R_JUMP: state_d = IDLE;
      default:        state_d = IDLE;
    endcase
  end

  // Acceptance is masked during reset so hold never rises while rst_n is low in IDLE.
  assign hold_o = (state_q != IDLE) | (accept & rst_n);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      epc_q       <= 32'h0;
      cause_q     <= 32'h0;
      csr_we_o    <= 1'b0;
      csr_waddr_o <= 12'h000;
      csr_wdata_o <= 32'h0;
      jump_flag_o <= 1'b0;
      jump_addr_o <= 32'h0;
    end else begin
      state_q     <= state_d;
      epc_q       <= epc_d;
      cause_q     <= cause_d;
      csr_we_o    <= csr_we_d;
      csr_waddr_o <= csr_waddr_d;
      csr_wdata_o <= csr_wdata_d;
      jump_flag_o <= jump_flag_d;
      jump_addr_o <= jump_addr_d;
    end
  end

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// Directed vector bench for csr_trap_ctrl: one table row per clock cycle plus an MRET handshake.
module tb_csr_trap_ctrl;

  typedef struct {
    logic        rst_n;
    logic        ecall;
    logic        ebreak;
    logic        mret;
    logic        busy;
    logic        irq;
    logic [31:0] addr;
    logic [31:0] mstatus;
    logic [31:0] mie;
    logic [31:0] mtvec;
    logic [31:0] mepc;
    logic        e_we;
    logic [11:0] e_waddr;
    logic [31:0] e_wdata;
    logic        e_hold;
    logic        e_jf;
    logic [31:0] e_ja;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        inst_ecall_i, inst_ebreak_i, inst_mret_i, ex_busy_i, timer_irq_i;
  logic [31:0] inst_addr_i, mstatus_i, mie_i, mtvec_i, mepc_i;
  logic        csr_we_o, hold_o, jump_flag_o;
  logic [11:0] csr_waddr_o;
  logic [31:0] csr_wdata_o, jump_addr_o;

  int checks = 0;
  int failures = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  csr_trap_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .inst_ecall_i (inst_ecall_i),
    .inst_ebreak_i(inst_ebreak_i),
    .inst_mret_i  (inst_mret_i),
    .inst_addr_i  (inst_addr_i),
    .ex_busy_i    (ex_busy_i),
    .timer_irq_i  (timer_irq_i),
    .mstatus_i    (mstatus_i),
    .mie_i        (mie_i),
    .mtvec_i      (mtvec_i),
    .mepc_i       (mepc_i),
    .csr_we_o     (csr_we_o),
    .csr_waddr_o  (csr_waddr_o),
    .csr_wdata_o  (csr_wdata_o),
    .hold_o       (hold_o),
    .jump_flag_o  (jump_flag_o),
    .jump_addr_o  (jump_addr_o)
  );

  task automatic check(input string name, input int row, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
    end
  endtask

  // Request/input fields, then expected we, waddr, wdata, hold, jump_flag, jump_addr.
  task automatic add(input logic r, input logic ec, input logic eb, input logic mr,
                     input logic bz, input logic iq, input logic [31:0] ad,
                     input logic [31:0] ms, input logic [31:0] me, input logic [31:0] tv,
                     input logic [31:0] ep, input logic we, input logic [11:0] wa,
                     input logic [31:0] wd, input logic hd, input logic jf,
                     input logic [31:0] ja);
    vec_t v;
    v.rst_n = r; v.ecall = ec; v.ebreak = eb; v.mret = mr; v.busy = bz; v.irq = iq;
    v.addr = ad; v.mstatus = ms; v.mie = me; v.mtvec = tv; v.mepc = ep;
    v.e_we = we; v.e_waddr = wa; v.e_wdata = wd; v.e_hold = hd; v.e_jf = jf; v.e_ja = ja;
    vecs.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    rst_n = v.rst_n; inst_ecall_i = v.ecall; inst_ebreak_i = v.ebreak; inst_mret_i = v.mret;
    ex_busy_i = v.busy; timer_irq_i = v.irq; inst_addr_i = v.addr; mstatus_i = v.mstatus;
    mie_i = v.mie; mtvec_i = v.mtvec; mepc_i = v.mepc;
  endtask

  initial begin
    bit found;
    vec_t v;
    // Reset with every request asserted, then release with inputs idle.
    add(0, 1, 1, 1, 0, 1, 32'h100, 32'h8, 32'h80, 32'h200, 32'h0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 1, 1, 0, 1, 32'h100, 32'h8, 32'h80, 32'h200, 32'h0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 32'h0, 32'h8, 32'h80, 32'h200, 32'h0, 0, 0, 0, 0, 0, 0);
    // ECALL; the EBREAK/MRET raised mid-sequence must be ignored, not queued.
    add(1, 1, 0, 0, 0, 0, 32'h100, 32'h8, 32'h0, 32'h200, 32'h0, 0, 0, 0, 1, 0, 0);
    add(1, 0, 0, 0, 0, 0, 32'h0, 32'h8, 32'h0, 32'h200, 32'h0, 1, 12'h341, 32'h100, 1, 0, 0);
    add(1, 0, 1, 1, 0, 0, 32'h0, 32'h8, 32'h0, 32'h200, 32'h0, 1, 12'h342, 32'd11, 1, 0, 0);
    add(1, 0, 0, 0, 0, 0, 32'h0, 32'h8, 32'h0, 32'h200, 32'h0, 1, 12'h300, 32'h1880, 1, 0, 0);
    add(1, 0, 0, 0, 0, 0, 32'h0, 32'h8, 32'h0, 32'h200, 32'h0, 0, 0, 0, 1, 1, 32'h200);
    add(1, 0, 0, 0, 0, 0, 32'h0, 32'h8, 32'h0, 32'h200, 32'h0, 0, 0, 0, 0, 0, 0);
    // Vectored timer interrupt.
    add(1, 0, 0, 0, 0, 1, 32'h400, 32'h8, 32'h80, 32'h201, 32'h0, 0, 0, 0, 1, 0, 0);
    add(1, 0, 0, 0, 0, 0, 32'h0, 32'h8, 32'h80, 32'h201, 32'h0, 1, 12'h341, 32'h400, 1, 0, 0);
    add(1, 0, 0, 0, 0, 0, 32'h0, 32'h8, 32'h80, 32'h201, 32'h0,
        1, 12'h342, 32'h8000_0007, 1, 0, 0);
    add(1, 0, 0, 0, 0, 0, 32'h0, 32'h8, 32'h80, 32'h201, 32'h0, 1, 12'h300, 32'h1880, 1, 0, 0);
    add(1, 0, 0, 0, 0, 0, 32'h0, 32'h8, 32'h80, 32'h201, 32'h0, 0, 0, 0, 1, 1, 32'h21C);
    add(1, 0, 0, 0, 0, 0, 32'h0, 32'h8, 32'h80, 32'h201, 32'h0, 0, 0, 0, 0, 0, 0);
    // Interrupt masked by MIE=0.
    add(1, 0, 0, 0, 0, 1, 32'h400, 32'h0, 32'h80, 32'h201, 32'h0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 1, 32'h400, 32'h0, 32'h80, 32'h201, 32'h0, 0, 0, 0, 0, 0, 0);
    // Deferred by ex_busy for 3 cycles, then taken; misaligned mtvec acts as direct.
    add(1, 0, 0, 0, 1, 1, 32'h500, 32'h8, 32'h80, 32'h203, 32'h0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 1, 1, 32'h500, 32'h8, 32'h80, 32'h203, 32'h0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 1, 1, 32'h500, 32'h8, 32'h80, 32'h203, 32'h0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 1, 32'h500, 32'h8, 32'h80, 32'h203, 32'h0, 0, 0, 0, 1, 0, 0);
    add(1, 0, 0, 0, 0, 0, 32'h0, 32'h8, 32'h80, 32'h203, 32'h0, 1, 12'h341, 32'h500, 1, 0, 0);
    add(1, 0, 0, 0, 0, 0, 32'h0, 32'h8, 32'h80, 32'h203, 32'h0,
        1, 12'h342, 32'h8000_0007, 1, 0, 0);
    add(1, 0, 0, 0, 0, 0, 32'h0, 32'h8, 32'h80, 32'h203, 32'h0, 1, 12'h300, 32'h1880, 1, 0, 0);
    add(1, 0, 0, 0, 0, 0, 32'h0, 32'h8, 32'h80, 32'h203, 32'h0, 0, 0, 0, 1, 1, 32'h200);
    add(1, 0, 0, 0, 0, 0, 32'h0, 32'h8, 32'h80, 32'h203, 32'h0, 0, 0, 0, 0, 0, 0);
    // MRET.
    add(1, 0, 0, 1, 0, 0, 32'h0, 32'h1880, 32'h0, 32'h200, 32'h104, 0, 0, 0, 1, 0, 0);
    add(1, 0, 0, 0, 0, 0, 32'h0, 32'h1880, 32'h0, 32'h200, 32'h104,
        1, 12'h300, 32'h1888, 1, 0, 0);
    add(1, 0, 0, 0, 0, 0, 32'h0, 32'h1880, 32'h0, 32'h200, 32'h104, 0, 0, 0, 1, 1, 32'h104);
    add(1, 0, 0, 0, 0, 0, 32'h0, 32'h1880, 32'h0, 32'h200, 32'h104, 0, 0, 0, 0, 0, 0);
    // ECALL beats a pending interrupt; synchronous cause jumps direct even in vectored mode.
    add(1, 1, 0, 0, 0, 1, 32'h600, 32'h8, 32'h80, 32'h201, 32'h0, 0, 0, 0, 1, 0, 0);
    add(1, 0, 0, 0, 0, 0, 32'h0, 32'h8, 32'h80, 32'h201, 32'h0, 1, 12'h341, 32'h600, 1, 0, 0);
    add(1, 0, 0, 0, 0, 0, 32'h0, 32'h8, 32'h80, 32'h201, 32'h0, 1, 12'h342, 32'd11, 1, 0, 0);
    add(1, 0, 0, 0, 0, 0, 32'h0, 32'h8, 32'h80, 32'h201, 32'h0, 1, 12'h300, 32'h1880, 1, 0, 0);
    add(1, 0, 0, 0, 0, 0, 32'h0, 32'h8, 32'h80, 32'h201, 32'h0, 0, 0, 0, 1, 1, 32'h200);
    add(1, 0, 0, 0, 0, 0, 32'h0, 32'h8, 32'h80, 32'h201, 32'h0, 0, 0, 0, 0, 0, 0);
    // EBREAK beats MRET; MIE=0 on entry gives MPIE=0.
    add(1, 0, 1, 1, 0, 0, 32'h700, 32'h0, 32'h0, 32'h300, 32'h0, 0, 0, 0, 1, 0, 0);
    add(1, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h300, 32'h0, 1, 12'h341, 32'h700, 1, 0, 0);
    add(1, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h300, 32'h0, 1, 12'h342, 32'd3, 1, 0, 0);
    add(1, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h300, 32'h0, 1, 12'h300, 32'h1800, 1, 0, 0);
    add(1, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h300, 32'h0, 0, 0, 0, 1, 1, 32'h300);
    add(1, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h300, 32'h0, 0, 0, 0, 0, 0, 0);
    // Reset at N+2 aborts: the mcause write still shows, then nothing and no jump.
    add(1, 1, 0, 0, 0, 0, 32'h800, 32'h8, 32'h0, 32'h200, 32'h0, 0, 0, 0, 1, 0, 0);
    add(1, 0, 0, 0, 0, 0, 32'h0, 32'h8, 32'h0, 32'h200, 32'h0, 1, 12'h341, 32'h800, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 32'h0, 32'h8, 32'h0, 32'h200, 32'h0, 1, 12'h342, 32'd11, 1, 0, 0);
    add(1, 0, 0, 0, 0, 0, 32'h0, 32'h8, 32'h0, 32'h200, 32'h0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 32'h0, 32'h8, 32'h0, 32'h200, 32'h0, 0, 0, 0, 0, 0, 0);

    v = vecs[0];
    drive(v);
    @(posedge clk);
    #1;
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      @(negedge clk);
      check("csr_we", i, {31'h0, csr_we_o}, {31'h0, vecs[i].e_we});
      check("csr_waddr", i, {20'h0, csr_waddr_o}, {20'h0, vecs[i].e_waddr});
      check("csr_wdata", i, csr_wdata_o, vecs[i].e_wdata);
      check("hold", i, {31'h0, hold_o}, {31'h0, vecs[i].e_hold});
      check("jump_flag", i, {31'h0, jump_flag_o}, {31'h0, vecs[i].e_jf});
      check("jump_addr", i, jump_addr_o, vecs[i].e_ja);
      @(posedge clk);
      #1;
    end

    // MRET handshake: bounded wait for the redirect, then a one-cycle pulse.
    v = vecs[vecs.size() - 1];
    v.mret = 1'b1; v.mstatus = 32'h80; v.mepc = 32'h44;
    drive(v);
    @(posedge clk);
    #1;
    inst_mret_i = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      @(negedge clk);
      if (csr_we_o) check("mret_wdata", 100, csr_wdata_o, 32'h1888);
      if (jump_flag_o) found = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    check("mret_jump_seen", 100, {31'h0, found}, 32'h1);
    check("mret_jump_addr", 100, jump_addr_o, 32'h44);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("pulse_flag", 101, {31'h0, jump_flag_o}, 32'h0);
    check("pulse_addr", 101, jump_addr_o, 32'h0);
    check("pulse_hold", 101, {31'h0, hold_o}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
